// File: rtl/mips_hazard_unit.sv
// mips_hazard_unit
//   Hazard detection and forwarding control for a 5-stage MIPS pipeline.
//   Tracks the EX, MEM and WB occupants internally and derives stall,
//   bubble, flush and operand-forwarding selects from the ID instruction.
//
// Build option:
//   MIPS_HAZARD_FORWARD_EN  defined   -> EX operands forwarded from MEM/WB;
//                                        only a load-use in EX stalls.
//                           undefined -> no forwarding; ID stalls on any
//                                        EX or MEM producer match.
//
// Parameters:
//   REG_AW  register-address width
//   CNT_W   stall-counter width
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   id_valid       ID stage holds a real instruction
//   id_rs, id_rt   ID source registers
//   id_use_rs/rt   ID instruction reads rs / rt
//   id_dst         ID destination (after regdst select)
//   id_regwrite    ID instruction writes a register
//   id_memread     ID instruction is a load
//   mem_redirect   taken branch/jump resolved in MEM
//   stall          hold PC and IF/ID
//   bubble_ex      load a no-op into ID/EX
//   flush          clear IF/ID, ID/EX and EX/MEM
//   fwd_a, fwd_b   EX operand select: 00 bank, 01 WB value, 10 MEM ALU result
//   stall_cnt      saturating count of stall cycles

module mips_hazard_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              mem_redirect,
  output logic              stall,
  output logic              bubble_ex,
  output logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  // EX slot
  logic [REG_AW-1:0] r_ex_rs;
  logic [REG_AW-1:0] r_ex_rt;
  logic              r_ex_use_rs;
  logic              r_ex_use_rt;
  logic [REG_AW-1:0] r_ex_dst;
  logic              r_ex_rw;
  logic              r_ex_mr;
  // MEM slot
  logic [REG_AW-1:0] r_mem_dst;
  logic              r_mem_rw;
  logic              r_mem_mr;
  // WB slot
  logic [REG_AW-1:0] r_wb_dst;
  logic              r_wb_rw;

  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_haz;
  logic              w_stall;
  logic              w_id_live;

  // Register 0 is hardwired, so it never produces a dependency.
  function automatic logic f_match(input logic              use_f,
                                   input logic [REG_AW-1:0] src,
                                   input logic [REG_AW-1:0] dst,
                                   input logic              rw);
    return use_f && rw && (src == dst) && (dst != '0);
  endfunction

  always_comb begin
    w_haz = 1'b0;
`ifdef MIPS_HAZARD_FORWARD_EN
    w_haz = id_valid && r_ex_mr &&
            (f_match(id_use_rs, id_rs, r_ex_dst, r_ex_rw) ||
             f_match(id_use_rt, id_rt, r_ex_dst, r_ex_rw));
`else
    w_haz = id_valid &&
            (f_match(id_use_rs, id_rs, r_ex_dst, r_ex_rw)   ||
             f_match(id_use_rt, id_rt, r_ex_dst, r_ex_rw)   ||
             f_match(id_use_rs, id_rs, r_mem_dst, r_mem_rw) ||
             f_match(id_use_rt, id_rt, r_mem_dst, r_mem_rw));
`endif
    // Reset and redirect both take precedence over a pending stall.
    w_stall = w_haz && !rst && !mem_redirect;
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
`ifdef MIPS_HAZARD_FORWARD_EN
    if (!rst) begin
      if (f_match(r_ex_use_rs, r_ex_rs, r_mem_dst, r_mem_rw) && !r_mem_mr)
        fwd_a = 2'b10;
      else if (f_match(r_ex_use_rs, r_ex_rs, r_wb_dst, r_wb_rw))
        fwd_a = 2'b01;
      if (f_match(r_ex_use_rt, r_ex_rt, r_mem_dst, r_mem_rw) && !r_mem_mr)
        fwd_b = 2'b10;
      else if (f_match(r_ex_use_rt, r_ex_rt, r_wb_dst, r_wb_rw))
        fwd_b = 2'b01;
    end
`endif
  end

`ifndef MIPS_HAZARD_FORWARD_EN
  // Slot fields that only matter for forwarding are tracked but unread here.
  logic w_unused;
  assign w_unused = ^{r_ex_rs, r_ex_rt, r_ex_use_rs, r_ex_use_rt,
                      r_mem_mr, r_wb_dst, r_wb_rw};
`endif

  assign w_id_live = id_valid && !w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_rs     <= '0;
      r_ex_rt     <= '0;
      r_ex_use_rs <= 1'b0;
      r_ex_use_rt <= 1'b0;
      r_ex_dst    <= '0;
      r_ex_rw     <= 1'b0;
      r_ex_mr     <= 1'b0;
      r_mem_dst   <= '0;
      r_mem_rw    <= 1'b0;
      r_mem_mr    <= 1'b0;
      r_wb_dst    <= '0;
      r_wb_rw     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      // The redirecting instruction itself sits in MEM and still retires.
      r_wb_dst <= r_mem_dst;
      r_wb_rw  <= r_mem_rw;
      if (mem_redirect) begin
        r_mem_dst <= '0;
        r_mem_rw  <= 1'b0;
        r_mem_mr  <= 1'b0;
      end else begin
        r_mem_dst <= r_ex_dst;
        r_mem_rw  <= r_ex_rw;
        r_mem_mr  <= r_ex_mr;
      end
      // A stalled, invalid or flushed ID instruction enters EX as a bubble.
      if (w_id_live && !mem_redirect) begin
        r_ex_rs     <= id_rs;
        r_ex_rt     <= id_rt;
        r_ex_use_rs <= id_use_rs;
        r_ex_use_rt <= id_use_rt;
        r_ex_dst    <= id_dst;
        r_ex_rw     <= id_regwrite;
        r_ex_mr     <= id_memread;
      end else begin
        r_ex_rs     <= '0;
        r_ex_rt     <= '0;
        r_ex_use_rs <= 1'b0;
        r_ex_use_rt <= 1'b0;
        r_ex_dst    <= '0;
        r_ex_rw     <= 1'b0;
        r_ex_mr     <= 1'b0;
      end
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall     = w_stall;
  assign bubble_ex = w_stall;
  assign flush     = mem_redirect && !rst;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mips_hazard_unit.sv
// tb_mips_hazard_unit
//   Directed-vector bench for mips_hazard_unit (CNT_W = 4 so saturation is
//   reachable). Expected values are hand-derived per build option.

module tb_mips_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] id_dst;
  logic       id_regwrite;
  logic       id_memread;
  logic       mem_redirect;
  logic       stall;
  logic       bubble_ex;
  logic       flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [3:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

`ifdef MIPS_HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  mips_hazard_unit #(.REG_AW(5), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_dst       (id_dst),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .mem_redirect (mem_redirect),
    .stall        (stall),
    .bubble_ex    (bubble_ex),
    .flush        (flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input int rs, input int rt,
                        input logic urs, input logic urt, input int dst,
                        input logic rw, input logic mr);
    id_valid    = v;
    id_rs       = rs[4:0];
    id_rt       = rt[4:0];
    id_use_rs   = urs;
    id_use_rt   = urt;
    id_dst      = dst[4:0];
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic nop();
    set_id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_redirect = 1'b0;
    nop();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int total;
    int k;
    bit exp_s;

    // Reset dominates: hazardous ID inputs and a redirect are ignored.
    rst = 1'b1;
    mem_redirect = 1'b1;
    set_id(1'b1, 3, 0, 1'b1, 1'b0, 3, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3, 3, 1'b1, 1'b1, 4, 1'b1, 1'b0);
    sample();
    check("rst_stall", stall, 0);
    check("rst_bubble", bubble_ex, 0);
    check("rst_flush", flush, 0);
    check("rst_fwd_a", fwd_a, 0);
    check("rst_fwd_b", fwd_b, 0);
    check("rst_cnt", stall_cnt, 0);

    // add $3,$1,$2 ; sub $4,$3,$5
    do_reset();
    set_id(1'b1, 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    sample();
    check("alu_stall0", stall, 0);
    tick();
    set_id(1'b1, 3, 5, 1'b1, 1'b1, 4, 1'b1, 1'b0);
    sample();
    check("alu_stall1", stall, FWD ? 0 : 1);
    tick();
`ifdef MIPS_HAZARD_FORWARD_EN
    nop();
    sample();
    check("alu_fwd_a", fwd_a, 2);
    check("alu_fwd_b", fwd_b, 0);
    check("alu_cnt", stall_cnt, 0);
`else
    sample();
    check("alu_stall2", stall, 1);
    check("alu_fwd_a_s", fwd_a, 0);
    tick();
    sample();
    check("alu_stall3", stall, 0);
    tick();
    nop();
    sample();
    check("alu_fwd_a", fwd_a, 0);
    check("alu_fwd_b", fwd_b, 0);
    check("alu_cnt", stall_cnt, 2);
`endif

    // lw $3,0($1) ; add $4,$3,$3
    do_reset();
    set_id(1'b1, 1, 0, 1'b1, 1'b0, 3, 1'b1, 1'b1);
    sample();
    check("lu_stall0", stall, 0);
    tick();
    set_id(1'b1, 3, 3, 1'b1, 1'b1, 4, 1'b1, 1'b0);
    sample();
    check("lu_stall1", stall, 1);
    check("lu_bubble1", bubble_ex, 1);
    tick();
`ifdef MIPS_HAZARD_FORWARD_EN
    sample();
    check("lu_stall2", stall, 0);
    tick();
    nop();
    sample();
    check("lu_fwd_a", fwd_a, 1);
    check("lu_fwd_b", fwd_b, 1);
    check("lu_cnt", stall_cnt, 1);
`else
    sample();
    check("lu_stall2", stall, 1);
    tick();
    sample();
    check("lu_stall3", stall, 0);
    tick();
    nop();
    sample();
    check("lu_fwd_a", fwd_a, 0);
    check("lu_fwd_b", fwd_b, 0);
    check("lu_cnt", stall_cnt, 2);
`endif

    // Producer of $0 (ALU and load), consumer directly behind or one gap later
    for (int mr = 0; mr < 2; mr++) begin
      for (int gap = 0; gap < 2; gap++) begin
        do_reset();
        set_id(1'b1, 1, 2, 1'b1, 1'b1, 0, 1'b1, mr[0]);
        tick();
        if (gap != 0) begin
          nop();
          tick();
        end
        set_id(1'b1, 0, 0, 1'b1, 1'b1, 4, 1'b1, 1'b0);
        sample();
        check("r0_stall_id", stall, 0);
        tick();
        nop();
        sample();
        check("r0_stall_ex", stall, 0);
        check("r0_fwd_a", fwd_a, 0);
        check("r0_fwd_b", fwd_b, 0);
        check("r0_cnt", stall_cnt, 0);
      end
    end

    // id_valid = 0 suppresses the stall and enters as a bubble
    do_reset();
    set_id(1'b1, 1, 0, 1'b1, 1'b0, 3, 1'b1, 1'b1);
    tick();
    set_id(1'b0, 3, 3, 1'b1, 1'b1, 4, 1'b1, 1'b1);
    sample();
    check("inv_stall", stall, 0);
    check("inv_bubble", bubble_ex, 0);
    tick();
    set_id(1'b1, 4, 4, 1'b1, 1'b1, 5, 1'b1, 1'b0);
    sample();
    check("inv_after_stall", stall, 0);

    // Redirect coinciding with a load-use stall
    do_reset();
    set_id(1'b1, 1, 0, 1'b1, 1'b0, 3, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3, 0, 1'b1, 1'b0, 5, 1'b1, 1'b1);
    mem_redirect = 1'b1;
    sample();
    check("rd_flush", flush, 1);
    check("rd_stall", stall, 0);
    check("rd_bubble", bubble_ex, 0);
    tick();
    mem_redirect = 1'b0;
    set_id(1'b1, 5, 3, 1'b1, 1'b1, 6, 1'b1, 1'b0);
    sample();
    check("rd_flush_off", flush, 0);
    check("rd_stall_next", stall, 0);
    check("rd_cnt", stall_cnt, 0);
    tick();
    nop();
    sample();
    check("rd_fwd_a", fwd_a, 0);
    check("rd_fwd_b", fwd_b, 0);

    // Saturation: hold lw $3,0($3) so every issue depends on its predecessor
    do_reset();
    set_id(1'b1, 3, 0, 1'b1, 1'b0, 3, 1'b1, 1'b1);
    total = 0;
    k = 0;
    while (total < 18) begin
      exp_s = FWD ? (k % 2 == 1) : (k % 3 != 0);
      sample();
      check($sformatf("sat_stall_c%0d", k), stall, int'(exp_s));
      check($sformatf("sat_cnt_c%0d", k), stall_cnt, (total > 15) ? 15 : total);
      if (exp_s) total++;
      tick();
      k++;
    end
    sample();
    check("sat_gap_stall", stall, 0);
    check("sat_cnt_hold", stall_cnt, 15);
    tick();
    sample();
    check("sat_pre_rst_stall", stall, 1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_stall", stall, 0);
    check("rst_mid_bubble", bubble_ex, 0);
    tick();
    check("rst_mid_cnt", stall_cnt, 0);
    rst = 1'b0;
    sample();
    check("post_rst_stall", stall, 0);
    check("post_rst_cnt", stall_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_hazard_unit.md
MIPS_HAZARD_UNIT -- requirements
Module: mips_hazard_unit

Interface
REQ-001 Parameter REG_AW, default 5, SHALL set the register-address width.
REQ-002 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 id_valid  in  1  SHALL mark a real instruction in the ID stage.
REQ-006 id_rs / id_rt  in  REG_AW  SHALL be the ID source registers.
REQ-007 id_use_rs / id_use_rt  in  1  SHALL mean the ID instruction reads rs / rt.
REQ-008 id_dst  in  REG_AW  SHALL be the ID destination after the regdst select.
REQ-009 id_regwrite / id_memread  in  1  SHALL mean the ID instruction writes a register / is a load.
REQ-010 mem_redirect  in  1  SHALL mean a taken branch or jump resolved in the MEM stage.
REQ-011 stall  out  1  SHALL hold PC and IF/ID.
REQ-012 bubble_ex  out  1  SHALL load a no-op into ID/EX.
REQ-013 flush  out  1  SHALL clear IF/ID, ID/EX and EX/MEM.
REQ-014 fwd_a / fwd_b  out  2  SHALL select the EX operand: 00 register bank, 01 WB value, 10 MEM ALU result.
REQ-015 stall_cnt  out  CNT_W  SHALL count stall cycles.

Function
REQ-016 Internal tracking SHALL hold the EX slot (rs, rt, use flags, dst, regwrite, memread), the MEM slot (dst, regwrite, memread) and the WB slot (dst, regwrite).
- Each cycle the slots SHALL shift ID->EX->MEM->WB.
REQ-017 Hazard match SHALL require all of: the consumer source use flag = 1, the source equals the producer dst, the producer regwrite = 1, and dst != 0.
- Register 0 SHALL never create a hazard or a forward.
REQ-018 Register-bank writes in WB SHALL be visible to ID in the same cycle (write-through bank), so the WB slot SHALL never cause a stall.
REQ-019 stall, bubble_ex and fwd_a/fwd_b SHALL be combinational from the ID inputs and the tracking slots.
- flush SHALL equal mem_redirect.
REQ-020 On stall: the EX slot SHALL load a bubble (regwrite = 0, memread = 0, use flags = 0), and bubble_ex SHALL be 1.
REQ-021 fwd_a SHALL be 10 when EX rs matches a MEM producer whose memread = 0; else 01 when EX rs matches a WB producer; else 00.
- MEM priority over WB SHALL apply.
- fwd_b SHALL follow the same rules for rt.
REQ-022 When mem_redirect = 1: flush SHALL be 1; stall and bubble_ex SHALL be 0; the EX and MEM slots SHALL be cleared to bubbles on the next edge.
- Redirect SHALL override a simultaneous stall.
REQ-023 id_valid = 0 SHALL suppress stall generation and SHALL enter the pipeline as a bubble.
REQ-024 stall_cnt SHALL increment by 1 each cycle stall = 1 and SHALL saturate at all ones.
- It SHALL not wrap.

Reset
REQ-025 While rst = 1: all slots SHALL clear to bubbles, stall_cnt SHALL be 0, and stall, bubble_ex, flush SHALL be 0 and fwd_a = fwd_b = 00 regardless of the inputs.
REQ-026 A reset asserted during a stall SHALL release the stall on the same cycle.
- The first post-reset cycle SHALL see empty slots.

Configuration
REQ-027 Macro MIPS_HAZARD_FORWARD_EN, defined: forwarding SHALL be as in REQ-021.
- stall SHALL be 1 only when the ID instruction matches an EX-slot producer with memread = 1 (one-cycle load-use).
REQ-028 Macro MIPS_HAZARD_FORWARD_EN, undefined:
- fwd_a and fwd_b SHALL be constant 00.
- stall SHALL be 1 when the ID instruction matches any EX-slot or MEM-slot producer.
- A dependent instruction SHALL therefore wait 2 cycles behind EX and 1 cycle behind MEM.

Verification
REQ-029 FORWARD_EN, sequence `add $3,$1,$2` then `sub $4,$3,$5` -> no stall; fwd_a = 10 on the sub EX cycle.
REQ-030 FORWARD_EN, sequence `lw $3,0($1)` then `add $4,$3,$3` -> stall = 1 for exactly one cycle; then fwd_a = fwd_b = 01; stall_cnt = 1.
REQ-031 FORWARD_EN undefined, sequence `add $3,...` then `sub $4,$3,...` -> stall for 2 cycles; fwd always 00; stall_cnt = 2.
REQ-032 Producer dst = 0 (`add $0,$1,$2`) then a consumer of $0 -> stall = 0 and fwd = 00 in both configurations.
REQ-033 mem_redirect = 1 in the same cycle as a load-use stall -> flush = 1, stall = 0, stall_cnt unchanged; the next cycle shows empty EX/MEM slots.
REQ-034 Preload stall_cnt near saturation (CNT_W = 4, 15 stall cycles), then 3 more stalls -> stall_cnt holds at 15; rst = 1 mid-stall -> stall = 0 and stall_cnt = 0 on the next edge.
